// File: rtl/pipe_stall_ctrl.sv
// Stall scheduler: merges the ID hazard request with a MUL/DIV occupancy FSM.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq_id,
  input  logic        flush,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic [5:0]  stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt_id,
  output logic [31:0] stall_cnt_ex
);

  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 2);

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [5:0] cnt;
  logic [5:0] cnt_nx;
  logic       req_ex;
  logic       req_id;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (md_start) begin
            state_nx = BUSY;
            cnt_nx   = md_is_div ? DIV_LD : MUL_LD;
          end
        end
        BUSY: begin
          if (cnt == '0) state_nx = IDLE;
          else           cnt_nx   = cnt - 6'd1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Reset gates the combinational requests so every output reads 0 in reset.
  always_comb begin
    req_ex  = 1'b0;
    md_done = 1'b0;
    unique case (state)
      IDLE: req_ex = md_start & ~flush & resetn;
      BUSY: begin
        req_ex  = (cnt != '0) & ~flush;
        md_done = (cnt == '0) & ~flush;
      end
      default: ;
    endcase
  end

  assign req_id  = stallreq_id & resetn & ~req_ex;
  assign md_busy = (state == BUSY);

  always_comb begin
    stall = '0;
    unique case (1'b1)
      req_ex:  stall = STALL_EX;
      req_id:  stall = STALL_ID;
      default: stall = '0;
    endcase
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] cnt_id_q;
  logic [31:0] cnt_ex_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_id_q <= '0;
      cnt_ex_q <= '0;
    end else begin
      if (stall == STALL_ID && cnt_id_q != '1)
        cnt_id_q <= cnt_id_q + 32'd1;
      if (stall == STALL_EX && cnt_ex_q != '1)
        cnt_ex_q <= cnt_ex_q + 32'd1;
    end
  end

  assign stall_cnt_id = cnt_id_q;
  assign stall_cnt_ex = cnt_ex_q;
`else
  assign stall_cnt_id = 32'b0;
  assign stall_cnt_ex = 32'b0;
`endif

endmodule
